// File: rtl/mfc_memory_responder_pkg.sv
// Shared constants, state type and address-range helper for the MFC
// memory responder slice.
// Optional build macro: MFC_MEM_ERR_EN (adds the out-of-range error flag).
package mfc_mem_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int ADDR_W     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_e;

  // True when any address bit above the RAM index field is set.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a, input int aw);
    logic [ADDR_W-1:0] hi;
    hi = a >> aw;
    return (hi != {ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/mfc_memory_responder_if.sv
// rd/wr/MFC handshake bundle between the CPU controller and the responder.
// Optional build macro: MFC_MEM_ERR_EN (adds err).
interface mfc_memory_responder_if #(
  parameter int DW = 16
);
  logic          rd;
  logic          wr;
  logic [15:0]   addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          MFC;
  logic          busy;
`ifdef MFC_MEM_ERR_EN
  logic          err;
`endif

  // Controller side: issues requests, observes completion.
  modport master (
    output rd, wr, addr, wdata,
`ifdef MFC_MEM_ERR_EN
    input  err,
`endif
    input  rdata, MFC, busy
  );

  // Responder side: services requests, reports completion.
  modport slave (
    input  rd, wr, addr, wdata,
`ifdef MFC_MEM_ERR_EN
    output err,
`endif
    output rdata, MFC, busy
  );

endinterface

// File: rtl/mfc_memory_responder_mem_array.sv
// Word-addressed DEPTH x DW RAM: synchronous write, registered read.
// The read register only loads when re is high, so it holds its value
// through writes and idle cycles; it clears on reset, the array does not.
module mfc_mem_array #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read port that holds between read completions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= {DW{1'b0}};
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mfc_memory_responder.sv
// Memory-side responder for the multicycle CPU rd/wr/MFC handshake.
// Latches the request, waits LATENCY cycles, performs the RAM access and
// holds MFC until the controller drops its request.
// Optional build macro: MFC_MEM_ERR_EN (suppress accesses with nonzero
// upper address bits and flag them on err alongside MFC).
module mfc_memory_responder
  import mfc_mem_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = DW_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mfc_memory_responder_if.slave  bus
);

  state_e        r_state;
  logic [3:0]    r_cnt;
  logic [15:0]   r_addr_l;
  logic [DW-1:0] r_wdata_l;
  logic          r_op_l;
  logic          r_mfc;
  logic          r_busy;
  logic          r_err;

  logic          w_req;
  logic          w_access;
  logic          w_op;
  logic [15:0]   w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_hit_err;
  logic          w_we;
  logic          w_re;
  logic [DW-1:0] w_rdata;

  assign w_req = bus.rd | bus.wr;

  // Select live inputs for a single-cycle access from IDLE, latched copies otherwise.
  always_comb begin
    w_access = 1'b0;
    w_op     = r_op_l;
    w_addr   = r_addr_l;
    w_wdata  = r_wdata_l;
    if (r_state == S_IDLE) begin
      w_access = w_req && (LATENCY == 1);
      w_op     = bus.wr ? OP_WR : OP_RD;
      w_addr   = bus.addr;
      w_wdata  = bus.wdata;
    end else if (r_state == S_BUSY) begin
      w_access = (r_cnt == 4'd0);
    end else begin
      w_access = 1'b0;
    end
  end

`ifdef MFC_MEM_ERR_EN
  assign w_hit_err = addr_out_of_range(w_addr, AW);
`else
  logic w_unused_addr_hi;
  assign w_hit_err        = 1'b0;
  assign w_unused_addr_hi = ^w_addr[15:AW];
`endif

  assign w_we = w_access && (w_op == OP_WR) && !w_hit_err;
  assign w_re = w_access && (w_op == OP_RD) && !w_hit_err;

  mfc_mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (w_addr[AW-1:0]),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (w_addr[AW-1:0]),
    .rdata (w_rdata)
  );

  // Handshake FSM with latency counter, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr_l  <= 16'd0;
      r_wdata_l <= {DW{1'b0}};
      r_op_l    <= OP_RD;
      r_mfc     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr_l  <= bus.addr;
            r_wdata_l <= bus.wdata;
            r_op_l    <= bus.wr ? OP_WR : OP_RD;
            r_busy    <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_DONE;
              r_cnt   <= 4'd0;
              r_mfc   <= 1'b1;
              r_err   <= w_hit_err;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end else begin
            r_mfc  <= 1'b0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_mfc   <= 1'b1;
            r_err   <= w_hit_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (!w_req) begin
            r_state <= S_IDLE;
            r_mfc   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_mfc   <= 1'b0;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MFC   = r_mfc;
  assign bus.busy  = r_busy;
  assign bus.rdata = w_rdata;
`ifdef MFC_MEM_ERR_EN
  assign bus.err   = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_err;
`endif

endmodule

// File: tb/tb_mfc_memory_responder.sv
// Directed bench for mfc_memory_responder (AW=8, DW=16, LATENCY=2).
module tb_mfc_memory_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mfc_memory_responder_if #(.DW(16)) bus ();

  mfc_memory_responder #(
    .AW      (8),
    .DW      (16),
    .LATENCY (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.rd    = r;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  initial begin
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    tick(); tick();
    check("rst_mfc",   {15'd0, bus.MFC},  16'h0000);
    check("rst_busy",  {15'd0, bus.busy}, 16'h0000);
    check("rst_rdata", bus.rdata,         16'h0000);
    rst = 1'b1;
    tick();

    // Write A5C3 to word 5; change inputs after the sample edge.
    req(1'b0, 1'b1, 16'h0005, 16'hA5C3);
    tick();
    check("wr_t0_mfc",  {15'd0, bus.MFC},  16'h0000);
    check("wr_t0_busy", {15'd0, bus.busy}, 16'h0001);
    bus.addr  = 16'h0009;
    bus.wdata = 16'h0000;
    tick();
    check("wr_t1_mfc", {15'd0, bus.MFC}, 16'h0000);
    tick();
    check("wr_t2_mfc", {15'd0, bus.MFC}, 16'h0001);
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check("wr_drop_mfc",  {15'd0, bus.MFC},  16'h0000);
    check("wr_drop_busy", {15'd0, bus.busy}, 16'h0000);

    // Read back word 5 and hold the request for five cycles.
    req(1'b1, 1'b0, 16'h0005, 16'h0000);
    tick();
    tick();
    check("rd_t1_mfc", {15'd0, bus.MFC}, 16'h0000);
    tick();
    check("rd_t2_mfc",   {15'd0, bus.MFC}, 16'h0001);
    check("rd_t2_rdata", bus.rdata,        16'hA5C3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rd_hold_mfc", {15'd0, bus.MFC}, 16'h0001);
    end
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check("rd_drop_mfc",   {15'd0, bus.MFC}, 16'h0000);
    check("rd_drop_rdata", bus.rdata,        16'hA5C3);

    // Reassert immediately: a fresh access with MFC at +2.
    req(1'b1, 1'b0, 16'h0005, 16'h0000);
    tick();
    check("re_t0_mfc",  {15'd0, bus.MFC},  16'h0000);
    check("re_t0_busy", {15'd0, bus.busy}, 16'h0001);
    tick();
    check("re_t1_mfc", {15'd0, bus.MFC}, 16'h0000);
    tick();
    check("re_t2_mfc", {15'd0, bus.MFC}, 16'h0001);
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // rd and wr together: write wins, rdata untouched.
    req(1'b1, 1'b1, 16'h0003, 16'h1234);
    tick(); tick(); tick();
    check("both_mfc",   {15'd0, bus.MFC}, 16'h0001);
    check("both_rdata", bus.rdata,        16'hA5C3);
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Read word 3, dropping rd during BUSY: access still completes.
    req(1'b1, 1'b0, 16'h0003, 16'h0000);
    tick();
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick(); tick();
    check("rd3_mfc",   {15'd0, bus.MFC}, 16'h0001);
    check("rd3_rdata", bus.rdata,        16'h1234);
    tick();
    check("rd3_drop_mfc", {15'd0, bus.MFC}, 16'h0000);

    // Seed word 7, then abort a write of FFFF with reset.
    req(1'b0, 1'b1, 16'h0007, 16'h0BEE);
    tick(); tick(); tick();
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    req(1'b0, 1'b1, 16'h0007, 16'hFFFF);
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    check("abort_mfc",   {15'd0, bus.MFC},  16'h0000);
    check("abort_busy",  {15'd0, bus.busy}, 16'h0000);
    check("abort_rdata", bus.rdata,         16'h0000);
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    req(1'b1, 1'b0, 16'h0007, 16'h0000);
    tick(); tick(); tick();
    check("rd7_mfc",   {15'd0, bus.MFC}, 16'h0001);
    check("rd7_rdata", bus.rdata,        16'h0BEE);
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Out-of-range address 0x0100.
    req(1'b0, 1'b1, 16'h0000, 16'h5555);
    tick(); tick(); tick();
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    req(1'b0, 1'b1, 16'h0100, 16'hBEEF);
    tick(); tick(); tick();
    check("oor_mfc", {15'd0, bus.MFC}, 16'h0001);
`ifdef MFC_MEM_ERR_EN
    check("oor_err", {15'd0, bus.err}, 16'h0001);
`endif
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
`ifdef MFC_MEM_ERR_EN
    check("oor_err_clr", {15'd0, bus.err}, 16'h0000);
`endif
    req(1'b1, 1'b0, 16'h0000, 16'h0000);
    tick(); tick(); tick();
    check("rd0_mfc", {15'd0, bus.MFC}, 16'h0001);
`ifdef MFC_MEM_ERR_EN
    check("rd0_rdata", bus.rdata, 16'h5555);
    check("rd0_err",   {15'd0, bus.err}, 16'h0000);
`else
    check("rd0_alias", bus.rdata, 16'hBEEF);
`endif
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check("end_mfc",  {15'd0, bus.MFC},  16'h0000);
    check("end_busy", {15'd0, bus.busy}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mfc_memory_responder.md
Name: mfc_memory_responder

Overview:
- Memory-side responder for the multicycle CPU's rd/wr/MFC memory handshake.
- CPUcontroller drives rd/wr together with the MAR address and MDR write data.
- This block services the access after a programmable wait, returns read data, and raises MFC (memory function complete).
- Sits between the datapath's MAR/MDR registers and a word-addressed synchronous RAM.

Parameters:
- AW, 8: RAM address width in words; DEPTH = 2**AW.
- DW, 16: data word width; matches the IR/MDR width.
- LATENCY, 2: cycles from request sample to MFC rise; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; rst=0 resets, rst=1 runs.
- rd  in  1  read request; held high by the controller until MFC is seen.
- wr  in  1  write request; same hold rule as rd.
- addr  in  16  MAR output; word address.
- wdata  in  DW  MDR output; write data.
- rdata  out  DW  read data; valid while MFC=1 after a read.
- MFC  out  1  access complete; level signal.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, MFC=0, busy=0, rdata=0. RAM contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a rising edge with rd|wr=1: latch addr, wdata and op (wr has priority when both are high), load cnt=LATENCY-1, go to BUSY.
  - If LATENCY=1, go directly to DONE and perform the access on that same edge.
- BUSY:
  - Decrement cnt each edge.
  - On the edge where cnt==0: perform the access, go to DONE.
    - Write: mem[addr_l[AW-1:0]] <= wdata_l.
    - Read: rdata <= mem[addr_l[AW-1:0]].
- DONE:
  - MFC=1 (registered, glitch-free).
  - Stay in DONE while rd|wr=1. The controller must drop the request after seeing MFC.
  - On the first edge with rd=wr=0: MFC->0 and go to IDLE.
  - A new request may be accepted on the following edge.
- Latency: the request is sampled at edge t0; MFC is high from edge t0+LATENCY until one edge after the request drops.
- Input isolation: addr/wdata changes after t0 are ignored because the latched copies are used. Request drops during BUSY are ignored and the access completes.
- rdata holds its last read value through writes and IDLE; it changes only on read completion or reset.
- Address width: only addr[AW-1:0] indexes the RAM; upper bits are ignored unless MEM_ERR_EN is defined.
- Back-to-back reads to the same word return identical data; a read after a write to the same word returns the new data.
- Reset mid-access: the FSM returns to IDLE, MFC drops immediately, and the aborted write is not committed.

Optional Feature:
- Macro: MFC_MEM_ERR_EN.
- Defined:
  - Adds output port err (1 bit).
  - If latched addr[15:AW] != 0, the access is suppressed: no write, rdata unchanged.
  - err=1 together with MFC in DONE; cleared on leaving DONE; reset value 0.
  - The handshake still completes, so the controller cannot deadlock.
- Undefined: no err port; upper address bits are ignored and accesses alias modulo DEPTH.

Decomposition:
- Package mfc_mem_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
  - Opcode constants OP_RD=1'b0, OP_WR=1'b1.
  - Default DW=16.
- Sub-module mfc_mem_array(clk, we, waddr/raddr, wdata, re, rdata): DEPTH x DW RAM with synchronous write and registered read.
- The top level contains the FSM, latency counter and request latches.

Test Plan:
- Reset, then wr=1, addr=16'h0005, wdata=16'hA5C3, LATENCY=2 -> MFC rises at t0+2; drop wr -> MFC=0 one edge later; busy low in IDLE.
- Read back: rd=1, addr=16'h0005 -> at t0+2 MFC=1 and rdata=16'hA5C3; rdata holds 16'hA5C3 after rd drops.
- Request hold: keep rd=1 for 5 cycles after MFC -> MFC stays 1, no second access occurs; deassert -> IDLE; reassert next cycle -> new access with MFC at +2.
- Simultaneous rd=wr=1 with wdata=16'h1234 at addr 3 -> a write is performed; a subsequent read of addr 3 returns 16'h1234.
- Assert rst=0 while in BUSY during a write of 16'hFFFF to addr 7 -> MFC=0 immediately; a later read of addr 7 returns the prior value.
- MFC_MEM_ERR_EN defined, addr=16'h0100 with AW=8 -> MFC=1 and err=1, no write; err=0 after the request drops.
- MFC_MEM_ERR_EN undefined, addr=16'h0100 -> aliases to word 0.
